// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the RAM port arbiter.
package mem_arb_pkg;
    localparam int NREQ_DEF   = 3;
    localparam int AW_DEF     = 8;
    localparam int DW_DEF     = 16;
    localparam int STARVE_DEF = 4;

    localparam int REQ_CORE   = 0;
    localparam int REQ_PANEL  = 1;
    localparam int REQ_LOADER = 2;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;
endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select: starving requester first, then requester 0,
// then round-robin over 1..NREQ-1 starting after rr_ptr.
module mem_arb_pick #(
    parameter int NREQ = 3,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] val,
    input  logic [NREQ-1:0] starve,
    input  logic [IW-1:0]   rr_ptr,
    output logic            any,
    output logic [IW-1:0]   win
);
    logic found;

    always_comb begin
        win   = '0;
        found = 1'b0;
        any   = |val;
        // starve[0] is never set, so scanning from 0 is harmless
        for (int k = 0; k < NREQ; k++) begin
            if (!found && val[k] && starve[k]) begin
                win   = IW'(k);
                found = 1'b1;
            end
        end
        if (!found && val[0]) begin
            win   = '0;
            found = 1'b1;
        end
        // first pass: indices above rr_ptr; second pass wraps to the bottom
        for (int k = 1; k < NREQ; k++) begin
            if (!found && val[k] && (k > int'(rr_ptr))) begin
                win   = IW'(k);
                found = 1'b1;
            end
        end
        for (int k = 1; k < NREQ; k++) begin
            if (!found && val[k]) begin
                win   = IW'(k);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one RAM rw port among NREQ requesters: zero-cycle grant when the RAM
// is ready, otherwise holds the winner stable; routes 1-cycle read data back.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int STARVE = STARVE_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NREQ-1:0]  req_val_i,
    input  logic [NREQ-1:0]  req_wen_i,
    input  logic [NREQ*AW-1:0] req_addr_i,
    input  logic [NREQ*DW-1:0] req_wdata_i,
    output logic [NREQ-1:0]  req_rdy_o,
    output logic [NREQ-1:0]  rsp_val_o,
    output logic [DW-1:0]    rsp_data_o,
    output logic             mem_val_o,
    output logic             mem_wen_o,
    output logic [AW-1:0]    mem_addr_o,
    output logic [DW-1:0]    mem_wdata_o,
    input  logic             mem_rdy_i,
    input  logic [DW-1:0]    mem_rdata_i,
    output logic             busy_o
);
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int AGW = $clog2(STARVE + 1);

    arb_state_e state_q, state_d;

    logic [IW-1:0]  held_q, win, sel, rr_ptr_q, rsp_id_q;
    logic           held_wen_q;
    logic [AW-1:0]  held_addr_q;
    logic [DW-1:0]  held_wdata_q;

    logic [NREQ-1:0][AGW-1:0] age_q;
    logic [NREQ-1:0] starve;

    logic           any_val, mem_val, accept, rsp_pend_q, rsp_on;
    logic           cur_wen;
    logic [AW-1:0]  cur_addr;
    logic [DW-1:0]  cur_wdata;

    always_comb begin
        for (int k = 0; k < NREQ; k++) starve[k] = (age_q[k] >= AGW'(STARVE));
    end

    mem_arb_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .val    (req_val_i),
        .starve (starve),
        .rr_ptr (rr_ptr_q),
        .any    (any_val),
        .win    (win)
    );

    always_comb begin
        state_d = state_q;
        if (state_q == HOLD) begin
            sel       = held_q;
            cur_wen   = held_wen_q;
            cur_addr  = held_addr_q;
            cur_wdata = held_wdata_q;
        end else begin
            sel       = win;
            cur_wen   = req_wen_i[win];
            cur_addr  = req_addr_i[int'(win)*AW +: AW];
            cur_wdata = req_wdata_i[int'(win)*DW +: DW];
        end
        // everything visible is forced quiet while reset is asserted
        mem_val = !rst_i && ((state_q == HOLD) || any_val);
        accept  = mem_val && mem_rdy_i;
        case (state_q)
            IDLE:    if (any_val && !mem_rdy_i) state_d = HOLD;
            HOLD:    if (mem_rdy_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rsp_on      = rsp_pend_q && !rst_i;
    assign mem_val_o   = mem_val;
    assign mem_wen_o   = mem_val && cur_wen;
    assign mem_addr_o  = mem_val ? cur_addr  : '0;
    assign mem_wdata_o = mem_val ? cur_wdata : '0;
    assign req_rdy_o   = accept ? (NREQ'(1) << sel) : '0;
    assign rsp_val_o   = rsp_on ? (NREQ'(1) << rsp_id_q) : '0;
    assign rsp_data_o  = rsp_on ? mem_rdata_i : '0;
    assign busy_o      = !rst_i && ((state_q == HOLD) || rsp_pend_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            held_q       <= '0;
            held_wen_q   <= 1'b0;
            held_addr_q  <= '0;
            held_wdata_q <= '0;
            rr_ptr_q     <= IW'(NREQ - 1);
            rsp_pend_q   <= 1'b0;
            rsp_id_q     <= '0;
            age_q        <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && any_val && !mem_rdy_i) begin
                held_q       <= win;
                held_wen_q   <= cur_wen;
                held_addr_q  <= cur_addr;
                held_wdata_q <= cur_wdata;
            end
            rsp_pend_q <= accept && !cur_wen;
            if (accept && !cur_wen) rsp_id_q <= sel;
            if (accept && sel != '0) rr_ptr_q <= sel;
            // requester 0 never ages; losers saturate at STARVE
            age_q[0] <= '0;
            for (int k = 1; k < NREQ; k++) begin
                if (req_val_i[k] && !(accept && sel == IW'(k))) begin
                    if (age_q[k] < AGW'(STARVE)) age_q[k] <= age_q[k] + 1'b1;
                end else begin
                    age_q[k] <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus hand-written stall,
// back-to-back and reset sequences against a small RAM model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  val, wen;
    logic [23:0] addr;
    logic [47:0] wdata;
    logic        mrdy;
    logic [15:0] mrdata;
    logic [2:0]  rdy_o, rsp_o;
    logic [15:0] rdata_o, mwdata_o;
    logic        mval_o, mwen_o, busy_o;
    logic [7:0]  maddr_o;

    logic [15:0] ram [256];
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0]       val, wen;
        logic [2:0][7:0]  addr;
        logic [2:0][15:0] wdata;
        logic             rdy;
        logic [2:0]       e_rdy, e_rsp;
        logic [15:0]      e_rdata;
        logic             e_mval, e_mwen;
        logic [7:0]       e_maddr;
        logic [15:0]      e_mwdata;
        logic             e_busy;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    mem_port_arbiter #(.NREQ(3), .AW(8), .DW(16), .STARVE(4)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_val_i  (val),
        .req_wen_i  (wen),
        .req_addr_i (addr),
        .req_wdata_i(wdata),
        .req_rdy_o  (rdy_o),
        .rsp_val_o  (rsp_o),
        .rsp_data_o (rdata_o),
        .mem_val_o  (mval_o),
        .mem_wen_o  (mwen_o),
        .mem_addr_o (maddr_o),
        .mem_wdata_o(mwdata_o),
        .mem_rdy_i  (mrdy),
        .mem_rdata_i(mrdata),
        .busy_o     (busy_o)
    );

    // RAM model: write on accept, read data registered one cycle later
    always @(posedge clk) begin
        if (mval_o && mrdy) begin
            if (mwen_o) ram[maddr_o] <= mwdata_o;
            else        mrdata       <= ram[maddr_o];
        end
    end

    // requester side of the hold protocol: a held request must stay valid
    always @(negedge clk) begin
        if (!rst && dut.state_q == HOLD && !val[dut.held_q]) begin
            n_fail++;
            $display("FAIL hold_protocol: req %0d withdrew while held", dut.held_q);
        end
    end

    function automatic vec_t mk(input logic [2:0] v, w, input logic [7:0] a0, a1, a2,
                                input logic [15:0] d0, d1, d2, input logic r,
                                input logic [2:0] er, es, input logic [15:0] ed,
                                input logic emv, emw, input logic [7:0] ema,
                                input logic [15:0] emd, input logic eb);
        vec_t x;
        x.val = v; x.wen = w; x.addr = {a2, a1, a0}; x.wdata = {d2, d1, d0}; x.rdy = r;
        x.e_rdy = er; x.e_rsp = es; x.e_rdata = ed; x.e_mval = emv; x.e_mwen = emw;
        x.e_maddr = ema; x.e_mwdata = emd; x.e_busy = eb;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input vec_t x);
        chk({tag, ".req_rdy"},   64'(rdy_o),    64'(x.e_rdy));
        chk({tag, ".rsp_val"},   64'(rsp_o),    64'(x.e_rsp));
        chk({tag, ".rsp_data"},  64'(rdata_o),  64'(x.e_rdata));
        chk({tag, ".mem_val"},   64'(mval_o),   64'(x.e_mval));
        chk({tag, ".mem_wen"},   64'(mwen_o),   64'(x.e_mwen));
        chk({tag, ".mem_addr"},  64'(maddr_o),  64'(x.e_maddr));
        chk({tag, ".mem_wdata"}, 64'(mwdata_o), 64'(x.e_mwdata));
        chk({tag, ".busy"},      64'(busy_o),   64'(x.e_busy));
    endtask

    // drive one cycle's inputs, compare mid-cycle, then advance past the edge
    task automatic run(input string tag, input vec_t x);
        val = x.val; wen = x.wen; addr = x.addr; wdata = x.wdata; mrdy = x.rdy;
        #4;
        check_outs(tag, x);
        @(posedge clk);
        #1;
    endtask

    vec_t z;

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'hA000 + 16'(i);
        mrdata = '0;
        rst = 1'b1; val = '0; wen = '0; addr = '0; wdata = '0; mrdy = 1'b1;
        z = mk(3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 16'h0, 16'h0, 16'h0, 1'b1,
               3'b000, 3'b000, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        run("reset", z);
        rst = 1'b0;

        // single read, round-robin writes, starvation, readback of writes
        vecs.push_back(mk(3'b001, 3'b000, 8'h10, 8'h00, 8'h00, 16'h0, 16'h0, 16'h0, 1, 3'b001, 3'b000, 16'h0000, 1, 0, 8'h10, 16'h0000, 0));
        vecs.push_back(mk(3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 16'h0, 16'h0, 16'h0, 1, 3'b000, 3'b001, 16'hA010, 0, 0, 8'h00, 16'h0000, 1));
        for (int i = 0; i < 2; i++) begin
            vecs.push_back(mk(3'b110, 3'b110, 8'h00, 8'h30, 8'h40, 16'h0, 16'h1111, 16'h2222, 1, 3'b010, 3'b000, 16'h0, 1, 1, 8'h30, 16'h1111, 0));
            vecs.push_back(mk(3'b110, 3'b110, 8'h00, 8'h30, 8'h40, 16'h0, 16'h1111, 16'h2222, 1, 3'b100, 3'b000, 16'h0, 1, 1, 8'h40, 16'h2222, 0));
        end
        vecs.push_back(z);
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(3'b101, 3'b101, 8'h50, 8'h00, 8'h60, 16'h5555, 16'h0, 16'h6666, 1, 3'b001, 3'b000, 16'h0, 1, 1, 8'h50, 16'h5555, 0));
        vecs.push_back(mk(3'b101, 3'b101, 8'h50, 8'h00, 8'h60, 16'h5555, 16'h0, 16'h6666, 1, 3'b100, 3'b000, 16'h0, 1, 1, 8'h60, 16'h6666, 0));
        vecs.push_back(mk(3'b101, 3'b101, 8'h50, 8'h00, 8'h60, 16'h5555, 16'h0, 16'h6666, 1, 3'b001, 3'b000, 16'h0, 1, 1, 8'h50, 16'h5555, 0));
        vecs.push_back(z);
        vecs.push_back(mk(3'b001, 3'b000, 8'h30, 8'h00, 8'h00, 16'h0, 16'h0, 16'h0, 1, 3'b001, 3'b000, 16'h0000, 1, 0, 8'h30, 16'h0000, 0));
        vecs.push_back(mk(3'b001, 3'b000, 8'h60, 8'h00, 8'h00, 16'h0, 16'h0, 16'h0, 1, 3'b001, 3'b001, 16'h1111, 1, 0, 8'h60, 16'h0000, 1));
        vecs.push_back(mk(3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 16'h0, 16'h0, 16'h0, 1, 3'b000, 3'b001, 16'h6666, 0, 0, 8'h00, 16'h0000, 1));

        foreach (vecs[i]) run($sformatf("vec%0d", i), vecs[i]);

        // stall: req 1 write held three cycles, req 0 arrives and waits
        run("stall1", mk(3'b010, 3'b010, 8'h00, 8'h20, 8'h00, 16'h0, 16'hBEEF, 16'h0, 0, 3'b000, 3'b000, 16'h0, 1, 1, 8'h20, 16'hBEEF, 0));
        run("stall2", mk(3'b011, 3'b010, 8'h10, 8'h20, 8'h00, 16'h0, 16'hBEEF, 16'h0, 0, 3'b000, 3'b000, 16'h0, 1, 1, 8'h20, 16'hBEEF, 1));
        run("stall3", mk(3'b011, 3'b010, 8'h10, 8'h20, 8'h00, 16'h0, 16'hBEEF, 16'h0, 0, 3'b000, 3'b000, 16'h0, 1, 1, 8'h20, 16'hBEEF, 1));
        run("stall4", mk(3'b011, 3'b010, 8'h10, 8'h20, 8'h00, 16'h0, 16'hBEEF, 16'h0, 1, 3'b010, 3'b000, 16'h0, 1, 1, 8'h20, 16'hBEEF, 1));
        run("stall5", mk(3'b001, 3'b000, 8'h10, 8'h00, 8'h00, 16'h0, 16'h0, 16'h0, 1, 3'b001, 3'b000, 16'h0, 1, 0, 8'h10, 16'h0000, 0));
        run("stall6", mk(3'b001, 3'b000, 8'h20, 8'h00, 8'h00, 16'h0, 16'h0, 16'h0, 1, 3'b001, 3'b001, 16'hA010, 1, 0, 8'h20, 16'h0000, 1));
        run("stall7", mk(3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 16'h0, 16'h0, 16'h0, 1, 3'b000, 3'b001, 16'hBEEF, 0, 0, 8'h00, 16'h0000, 1));

        // back-to-back reads
        run("b2b1", mk(3'b001, 3'b000, 8'h01, 8'h00, 8'h00, 16'h0, 16'h0, 16'h0, 1, 3'b001, 3'b000, 16'h0000, 1, 0, 8'h01, 16'h0, 0));
        run("b2b2", mk(3'b001, 3'b000, 8'h02, 8'h00, 8'h00, 16'h0, 16'h0, 16'h0, 1, 3'b001, 3'b001, 16'hA001, 1, 0, 8'h02, 16'h0, 1));
        run("b2b3", z.e_rsp == 3'b000 ? mk(3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 16'h0, 16'h0, 16'h0, 1, 3'b000, 3'b001, 16'hA002, 0, 0, 8'h00, 16'h0, 1) : z);

        // reset while req 1's read is held
        run("rsthold1", mk(3'b010, 3'b000, 8'h00, 8'h44, 8'h00, 16'h0, 16'h0, 16'h0, 0, 3'b000, 3'b000, 16'h0, 1, 0, 8'h44, 16'h0, 0));
        run("rsthold2", mk(3'b010, 3'b000, 8'h00, 8'h44, 8'h00, 16'h0, 16'h0, 16'h0, 0, 3'b000, 3'b000, 16'h0, 1, 0, 8'h44, 16'h0, 1));
        rst = 1'b1;
        run("rsthold3", mk(3'b010, 3'b000, 8'h00, 8'h44, 8'h00, 16'h0, 16'h0, 16'h0, 0, 3'b000, 3'b000, 16'h0, 0, 0, 8'h00, 16'h0, 0));
        rst = 1'b0;
        run("rsthold4", z);

        // reset in the cycle a read response is due
        run("rstrsp1", mk(3'b001, 3'b000, 8'h10, 8'h00, 8'h00, 16'h0, 16'h0, 16'h0, 1, 3'b001, 3'b000, 16'h0, 1, 0, 8'h10, 16'h0, 0));
        rst = 1'b1;
        run("rstrsp2", z);
        rst = 1'b0;
        run("rstrsp3", z);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
